mem_bus_sram_responder: RTL and testbench

MEM_BUS_SRAM_RESPONDER -- requirements
Module: mem_bus_sram_responder

---
 rtl/mem_bus_pkg.sv | 13 +
 rtl/mem_bus_sram_responder.sv | 127 ++++++++++++
 tb/tb_mem_bus_sram_responder.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-bus SRAM responder.
package mem_bus_pkg;

  // Width of the wait-state down-counter; holds WAIT_STATES in the range 0-7.
  localparam int WAIT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

endpackage

// File: rtl/mem_bus_sram_responder.sv
// Bridges a simple request/ack memory bus to an asynchronous 16-bit SRAM.
// Every SRAM-side and initiator-side output comes straight from a flop.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | strobes released, waiting for m_access; latches the request
// ACCESS | SRAM cycle in progress for WAIT_STATES+1 cycles
// ACK    | strobes released, m_ack pulse, write data still driven for hold
module mem_bus_sram_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] m_addr,
  input  logic [15:0] m_data_in,
  output logic [15:0] m_data_out,
  input  logic        m_access,
  output logic        m_ack,
  input  logic        m_wr_en,
  input  logic [1:0]  m_bytesel,
  output logic [18:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

  state_t                state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  wr_q;
  logic                  drop_q;

  // Request sequencing, SRAM strobe generation and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      wr_q        <= 1'b0;
      drop_q      <= 1'b0;
      m_ack       <= 1'b0;
      m_data_out  <= 16'h0000;
      sram_addr   <= '0;
      sram_dq_out <= 16'h0000;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
    end else begin
      m_ack <= 1'b0;
      case (state)
        IDLE: begin
          drop_q     <= 1'b0;
          sram_dq_oe <= 1'b0;
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_ub_n  <= 1'b1;
          sram_lb_n  <= 1'b1;
          if (m_access) begin
            sram_addr   <= m_addr;
            sram_dq_out <= m_data_in;
            wr_q        <= m_wr_en;
            wait_cnt    <= WAIT_LOAD;
            sram_ce_n   <= 1'b0;
            if (m_wr_en) begin
              // An all-zero byte select still runs the cycle but never pulses WE.
              sram_we_n  <= ~(|m_bytesel);
              sram_oe_n  <= 1'b1;
              sram_ub_n  <= ~m_bytesel[1];
              sram_lb_n  <= ~m_bytesel[0];
              sram_dq_oe <= 1'b1;
            end else begin
              sram_we_n  <= 1'b1;
              sram_oe_n  <= 1'b0;
              sram_ub_n  <= 1'b0;
              sram_lb_n  <= 1'b0;
              sram_dq_oe <= 1'b0;
            end
            state <= ACCESS;
          end
        end

        ACCESS: begin
          // A withdrawn request still finishes on the SRAM but gets no ack.
          if (!m_access) begin
            drop_q <= 1'b1;
          end
          if (wait_cnt == '0) begin
            if (!wr_q) begin
              m_data_out <= sram_dq_in;
            end
            m_ack      <= m_access & ~drop_q;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_dq_oe <= wr_q;
            state      <= ACK;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        ACK: begin
          sram_dq_oe <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_sram_responder.sv
// Directed bench for mem_bus_sram_responder: a WAIT_STATES=2 instance for
// single transfers and a WAIT_STATES=0 instance for back-to-back reads.
// Cycle k is the clock period after edge k; cycle 0 is the one in which
// m_access is first sampled high. Inputs and samples are taken at negedge.
module tb_mem_bus_sram_responder;
  import mem_bus_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // WAIT_STATES = 2 instance
  logic [19:1] m_addr;
  logic [15:0] m_data_in, m_data_out, sram_dq_out, sram_dq_in;
  logic        m_access, m_ack, m_wr_en, sram_dq_oe;
  logic [1:0]  m_bytesel;
  logic [18:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  // WAIT_STATES = 0 instance
  logic [19:1] z_addr;
  logic [15:0] z_data_in, z_data_out, z_dq_out, z_dq_in;
  logic        z_access, z_ack, z_wr_en, z_dq_oe;
  logic [1:0]  z_bytesel;
  logic [18:0] z_sram_addr;
  logic        z_ce_n, z_oe_n, z_we_n, z_ub_n, z_lb_n;

  mem_bus_sram_responder #(.WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_data_out(m_data_out),
    .m_access(m_access), .m_ack(m_ack), .m_wr_en(m_wr_en), .m_bytesel(m_bytesel),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  mem_bus_sram_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset),
    .m_addr(z_addr), .m_data_in(z_data_in), .m_data_out(z_data_out),
    .m_access(z_access), .m_ack(z_ack), .m_wr_en(z_wr_en), .m_bytesel(z_bytesel),
    .sram_addr(z_sram_addr), .sram_dq_out(z_dq_out), .sram_dq_in(z_dq_in),
    .sram_dq_oe(z_dq_oe), .sram_ce_n(z_ce_n), .sram_oe_n(z_oe_n),
    .sram_we_n(z_we_n), .sram_ub_n(z_ub_n), .sram_lb_n(z_lb_n)
  );

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({m_ack, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 7'b0111110) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 0111110",
               {m_ack, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe});
    end
    n_tests++;
    if (m_data_out !== 16'h0000 || sram_addr !== 19'h0 || sram_dq_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data: got data_out=%h addr=%h dq_out=%h expected all zero",
               m_data_out, sram_addr, sram_dq_out);
    end
    n_tests++;
    if (dut.state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected IDLE", dut.state);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic exp_oe_n, exp_ack;
    sram_dq_in = 16'hBEEF;
    m_addr     = 19'h12345;
    m_wr_en    = 1'b0;
    m_bytesel  = 2'b11;
    m_access   = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      exp_oe_n = !(c >= 1 && c <= 3);
      exp_ack  = (c == 4);
      n_tests++;
      if (sram_oe_n !== exp_oe_n || sram_ce_n !== exp_oe_n || m_ack !== exp_ack) begin
        n_fail++;
        $display("FAIL read_c%0d: got oe_n=%b ce_n=%b ack=%b expected oe_n=%b ce_n=%b ack=%b",
                 c, sram_oe_n, sram_ce_n, m_ack, exp_oe_n, exp_oe_n, exp_ack);
      end
      if (c == 2) begin
        n_tests++;
        if (sram_addr !== 19'h12345 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 ||
            sram_ub_n !== 1'b0 || sram_lb_n !== 1'b0) begin
          n_fail++;
          $display("FAIL read_bus: got addr=%h we_n=%b dq_oe=%b ub_n=%b lb_n=%b expected 12345 1 0 0 0",
                   sram_addr, sram_we_n, sram_dq_oe, sram_ub_n, sram_lb_n);
        end
      end
      if (c == 4) begin
        n_tests++;
        if (m_data_out !== 16'hBEEF) begin
          n_fail++;
          $display("FAIL read_data: got %h expected beef", m_data_out);
        end
        m_access = 1'b0;
      end
    end
  endtask

  task automatic test_write();
    logic exp_we_n, exp_oe, exp_ack;
    m_addr     = 19'h00ABC;
    m_data_in  = 16'hA55A;
    m_wr_en    = 1'b1;
    m_bytesel  = 2'b10;
    m_access   = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      exp_we_n = !(c >= 1 && c <= 3);
      exp_oe   = (c >= 1 && c <= 4);
      exp_ack  = (c == 4);
      n_tests++;
      if (sram_we_n !== exp_we_n || sram_dq_oe !== exp_oe || m_ack !== exp_ack || sram_oe_n !== 1'b1) begin
        n_fail++;
        $display("FAIL write_c%0d: got we_n=%b dq_oe=%b ack=%b oe_n=%b expected %b %b %b 1",
                 c, sram_we_n, sram_dq_oe, m_ack, sram_oe_n, exp_we_n, exp_oe, exp_ack);
      end
      if (c == 1) begin
        // Changing the request mid-transfer must not reach the SRAM.
        m_data_in = 16'h1234;
        m_bytesel = 2'b01;
        m_addr    = 19'h7FFFF;
        sram_dq_in = 16'h0000;
      end
      if (c == 3) begin
        n_tests++;
        if (sram_ub_n !== 1'b0 || sram_lb_n !== 1'b1 || sram_dq_out !== 16'hA55A || sram_addr !== 19'h00ABC) begin
          n_fail++;
          $display("FAIL write_bus: got ub_n=%b lb_n=%b dq_out=%h addr=%h expected 0 1 a55a 00abc",
                   sram_ub_n, sram_lb_n, sram_dq_out, sram_addr);
        end
      end
      if (c == 4) begin
        n_tests++;
        if (sram_dq_out !== 16'hA55A || m_data_out !== 16'hBEEF) begin
          n_fail++;
          $display("FAIL write_hold: got dq_out=%h data_out=%h expected a55a beef", sram_dq_out, m_data_out);
        end
        m_access = 1'b0;
      end
    end
  endtask

  task automatic test_no_bytes();
    int acks = 0;
    int we_lows = 0;
    m_data_in = 16'h5555;
    m_wr_en   = 1'b1;
    m_bytesel = 2'b00;
    m_access  = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (m_ack === 1'b1) acks++;
      if (sram_we_n !== 1'b1) we_lows++;
      if (c == 4) m_access = 1'b0;
    end
    n_tests++;
    if (acks != 1 || we_lows != 0 || m_data_out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL write_bytesel00: got acks=%0d we_low_cycles=%0d data_out=%h expected 1 0 beef",
               acks, we_lows, m_data_out);
    end
  endtask

  task automatic test_drop();
    int acks = 0;
    sram_dq_in = 16'h1357;
    m_addr     = 19'h00010;
    m_wr_en    = 1'b0;
    m_bytesel  = 2'b11;
    m_access   = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (m_ack === 1'b1) acks++;
      if (c == 2) m_access = 1'b0;
    end
    n_tests++;
    if (acks != 0) begin
      n_fail++;
      $display("FAIL drop_ack: got %0d acks expected 0", acks);
    end
    n_tests++;
    if (dut.state !== IDLE || sram_ce_n !== 1'b1 || sram_oe_n !== 1'b1 || m_data_out !== 16'h1357) begin
      n_fail++;
      $display("FAIL drop_end: got state=%0d ce_n=%b oe_n=%b data_out=%h expected IDLE 1 1 1357",
               dut.state, sram_ce_n, sram_oe_n, m_data_out);
    end
  endtask

  task automatic test_reset_mid();
    m_data_in = 16'hCAFE;
    m_wr_en   = 1'b1;
    m_bytesel = 2'b11;
    m_access  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (sram_we_n !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_pre: got we_n=%b expected 0", sram_we_n);
    end
    reset    = 1'b1;
    m_access = 1'b0;
    @(negedge clk);
    n_tests++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || m_ack !== 1'b0 || dut.state !== IDLE) begin
      n_fail++;
      $display("FAIL rstmid_post: got we_n=%b dq_oe=%b ack=%b state=%0d expected 1 0 0 IDLE",
               sram_we_n, sram_dq_oe, m_ack, dut.state);
    end
    reset = 1'b0;
    @(negedge clk);
    sram_dq_in = 16'h2468;
    m_wr_en    = 1'b0;
    m_access   = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 4) begin
        n_tests++;
        if (m_ack !== 1'b1 || m_data_out !== 16'h2468) begin
          n_fail++;
          $display("FAIL rstmid_read: got ack=%b data_out=%h expected 1 2468", m_ack, m_data_out);
        end
        m_access = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic exp_ack, exp_ce_n;
    z_addr    = 19'h00100;
    z_wr_en   = 1'b0;
    z_bytesel = 2'b11;
    z_dq_in   = 16'h0F0F;
    z_access  = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp_ack  = (c == 2 || c == 5);
      exp_ce_n = !(c == 1 || c == 4);
      n_tests++;
      if (z_ack !== exp_ack || z_ce_n !== exp_ce_n) begin
        n_fail++;
        $display("FAIL b2b_c%0d: got ack=%b ce_n=%b expected ack=%b ce_n=%b",
                 c, z_ack, z_ce_n, exp_ack, exp_ce_n);
      end
      if (c == 2) begin
        n_tests++;
        if (z_data_out !== 16'h0F0F) begin
          n_fail++;
          $display("FAIL b2b_data1: got %h expected 0f0f", z_data_out);
        end
        z_dq_in = 16'hF0F0;
      end
      if (c == 5) begin
        n_tests++;
        if (z_data_out !== 16'hF0F0) begin
          n_fail++;
          $display("FAIL b2b_data2: got %h expected f0f0", z_data_out);
        end
        z_access = 1'b0;
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    m_addr     = '0;
    m_data_in  = '0;
    m_access   = 1'b0;
    m_wr_en    = 1'b0;
    m_bytesel  = 2'b00;
    sram_dq_in = '0;
    z_addr     = '0;
    z_data_in  = '0;
    z_access   = 1'b0;
    z_wr_en    = 1'b0;
    z_bytesel  = 2'b00;
    z_dq_in    = '0;
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_no_bytes();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
